fmap_frame_buffer: RTL and testbench
====================================

# fmap_frame_buffer

Synthesizable capture-and-replay buffer for one CNN convolution-stage output frame. It accepts the raster-ordered multi-channel feature-map stream produced by a conv core, one pixel with all CO channels per beat, and stores the frame. It tracks the signed per-channel maximum and the winning channel index. Once the frame is complete, it replays the frame over a valid/ready stream in a selectable order. It sits between a conv/pool stage and the next consumer (next stage, classifier or debug readout), replacing bench-side fmap capture with hardware.

## Interface
- CO, 3, channel count (≥1)
- O_F_BW, 20, bits per channel sample, two's complement
- OUT_W, 24, frame width in pixels
- OUT_H, 24, frame height in pixels
- ORDER, 0, replay order: 0 = channel-major (ch, then y, then x; x fastest); 1 = pixel-major (y, then x, then ch; ch fastest)

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input beat valid (no backpressure on input side)
- i_fmap  in  CO*O_F_BW  channel c at bits [c*O_F_BW +: O_F_BW]
- i_clear  in  1  synchronous clear of o_overrun
- o_frame_done  out  1  one-cycle pulse, frame fully captured
- o_valid  out  1  replay element valid
- i_ready  in  1  replay consumer ready
- o_data  out  O_F_BW  replay sample
- o_ch  out  max(1,$clog2(CO))  channel tag of o_data
- o_x  out  $clog2(OUT_W)  column tag
- o_y  out  $clog2(OUT_H)  row tag
- o_last  out  1  high with the final replay element
- o_drain_done  out  1  one-cycle pulse after the final handshake
- o_ch_max  out  CO*O_F_BW  signed maximum per channel for the last frame
- o_argmax  out  max(1,$clog2(CO))  channel holding the largest o_ch_max
- o_overrun  out  1  sticky: input beat dropped during replay

## Operation
- States: CAPTURE, DONE, DRAIN. Reset enters CAPTURE with x = y = 0.
- CAPTURE: each i_valid beat writes sample c to mem[c][y][x] for all c.
  - x increments per beat. At x = OUT_W-1, x wraps to 0 and y increments.
  - The beat at (OUT_W-1, OUT_H-1) moves the block to DONE. x and y wrap to 0.
- Max tracking:
  - The first beat of a frame (x = y = 0) loads each channel max with that beat's sample.
  - Later beats update max = (s > max) ? s : max, using a signed compare.
  - argmax is updated in DONE from the final maxima. On ties, the lowest channel index wins.
  - o_ch_max and o_argmax stay stable from o_frame_done until the first beat of the next frame.
- DONE: lasts exactly one cycle. o_frame_done = 1 and the replay pointer is set to element 0. Next state is DRAIN.
- DRAIN: presents elements in ORDER.
  - Handshake is o_valid & i_ready. o_valid stays high and o_data/tags stay stable until a handshake occurs.
  - Element count is CO*OUT_W*OUT_H.
  - o_last is high on the final element. A handshake on it moves the block to CAPTURE, with o_drain_done = 1 in the following cycle.
- i_valid outside CAPTURE (in DONE or DRAIN): the beat is dropped, memory and maxima are unchanged, and o_overrun is set.
- o_overrun clears only on i_clear or reset. If i_clear and a drop occur in the same cycle, the set wins.
- Reset mid-frame or mid-drain aborts the operation: the block returns to CAPTURE empty and the partial frame is discarded. Memory contents do not need to be cleared.

## Timing
- Reset values: o_frame_done, o_valid, o_data, o_ch, o_x, o_y, o_last, o_drain_done, o_ch_max, o_argmax, o_overrun all 0.
- If the last capture beat is sampled at edge k:
  - o_frame_done is high in cycle k+1 (DONE).
  - o_valid rises in cycle k+2 with element 0.
- The memory read is synchronous. The replay path must prefetch so that, with i_ready held high, one element is delivered per cycle with no bubbles. Total drain time is CO*OUT_W*OUT_H cycles.
- After a handshake at edge m, the next element is visible in cycle m+1.
- Ready may toggle arbitrarily. No element may be skipped or duplicated.
- o_drain_done is high in the cycle after the final handshake. In that same cycle the state is CAPTURE and an i_valid beat is accepted as pixel (0,0).
- Input i_valid may be continuous with no gaps. It may also be gapped: x/y advance only on valid beats.

## Test plan
Bench parameters: CO=3, O_F_BW=20, OUT_W=OUT_H=4. Sample value = (c<<8)|(y<<4)|x unless stated otherwise.

- Continuous 16-beat frame, ORDER=0, i_ready=1 -> o_frame_done 1 cycle after beat 16. 48 elements on consecutive cycles: first o_data=0x000 (ch0,y0,x0), 17th 0x100, last 0x233 with o_last. Then o_drain_done.
- Same frame, ORDER=1 -> sequence 0x000, 0x100, 0x200, 0x001, … ending 0x233. Tags match the data.
- Random i_valid gaps plus random i_ready toggling -> identical 48-element sequence, no duplicates or skips, o_data stable while ready is low.
- Signed maxima: ch0 all -5 except one -1; ch1 peaks at 0x7FFFF; ch2 ties ch1 -> o_ch_max = {-1, 0x7FFFF, 0x7FFFF}, o_argmax = 1.
- Inject 3 i_valid beats during DRAIN -> o_overrun = 1, replay data unchanged. i_clear then returns o_overrun to 0. The next frame captures correctly from (0,0).
- Assert reset_n low at pixel (2,1) and again during drain element 20 -> all outputs 0. A new full frame then replays correctly with fresh maxima.

Source files
------------

// File: rtl/fmap_frame_buffer.sv
// fmap_frame_buffer: captures one raster-ordered, multi-channel feature-map frame,
// tracks the signed per-channel maximum and argmax, and then replays the frame over
// a valid/ready stream in channel-major (ORDER=0) or pixel-major (ORDER=1) order.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   i_valid, i_fmap                  capture beat (all CO channels of one pixel)
//   i_clear                          synchronous clear of o_overrun
//   o_frame_done                     one-cycle pulse when the frame is complete
//   o_valid, i_ready, o_data         replay stream handshake and sample
//   o_ch, o_x, o_y, o_last           replay element tags, final-element flag
//   o_drain_done                     one-cycle pulse after the final handshake
//   o_ch_max, o_argmax               per-channel signed maxima and winning channel
//   o_overrun                        sticky: an input beat was dropped outside capture
module fmap_frame_buffer #(
  parameter int unsigned CO     = 3,
  parameter int unsigned O_F_BW = 20,
  parameter int unsigned OUT_W  = 24,
  parameter int unsigned OUT_H  = 24,
  parameter int unsigned ORDER  = 0,
  localparam int unsigned CW    = (CO > 1) ? $clog2(CO) : 1,
  localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int unsigned DW    = CO * O_F_BW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic [DW-1:0]     i_fmap,
  input  logic              i_clear,
  output logic              o_frame_done,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [O_F_BW-1:0] o_data,
  output logic [CW-1:0]     o_ch,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic              o_last,
  output logic              o_drain_done,
  output logic [DW-1:0]     o_ch_max,
  output logic [CW-1:0]     o_argmax,
  output logic              o_overrun
);

  localparam int unsigned NPIX = OUT_W * OUT_H;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(CO - 1);
  localparam logic [XW-1:0] X_MAX = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(OUT_H - 1);

  typedef enum logic [1:0] {
    S_CAPTURE = 2'd0,
    S_DONE    = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       wx_q, wx_d;
  logic [YW-1:0]       wy_q, wy_d;
  logic [CW-1:0]       rc_q, rc_d;
  logic [XW-1:0]       rx_q, rx_d;
  logic [YW-1:0]       ry_q, ry_d;
  logic [DW-1:0]       max_q, max_d;
  logic [CW-1:0]       argmax_q, argmax_d;
  logic                frame_done_q, frame_done_d;
  logic                valid_q, valid_d;
  logic [O_F_BW-1:0]   data_q, data_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                last_q, last_d;
  logic                drain_done_q, drain_done_d;
  logic                overrun_q, overrun_d;

  logic [DW-1:0]       mem [NPIX];
  logic                mem_we;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;
  logic [DW-1:0]       rd_word;
  logic [O_F_BW-1:0]   rd_sel;
  logic                fetch;
  logic [CW-1:0]       fc;
  logic [XW-1:0]       fx;
  logic [YW-1:0]       fy;
  logic [O_F_BW-1:0]   s_val;
  logic [O_F_BW-1:0]   m_val;
  logic [CW-1:0]       best_ch;
  logic [O_F_BW-1:0]   best_val;

  // Frame storage: one word per pixel holding all channels.
  assign wr_addr = AW'(32'(wy_q) * OUT_W + 32'(wx_q));
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= i_fmap;
  end

  // Argmax over the final maxima; strict compare keeps the lowest index on ties.
  always_comb begin
    best_ch  = '0;
    best_val = max_q[O_F_BW-1:0];
    for (int c = 1; c < CO; c++) begin
      if ($signed(max_q[c*O_F_BW +: O_F_BW]) > $signed(best_val)) begin
        best_val = max_q[c*O_F_BW +: O_F_BW];
        best_ch  = CW'(c);
      end
    end
  end

  // Next-state, capture and replay-prefetch logic.
  always_comb begin
    state_d      = state_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    rc_d         = rc_q;
    rx_d         = rx_q;
    ry_d         = ry_q;
    max_d        = max_q;
    argmax_d     = argmax_q;
    frame_done_d = 1'b0;
    valid_d      = valid_q;
    data_d       = data_q;
    ch_d         = ch_q;
    x_d          = x_q;
    y_d          = y_q;
    last_d       = last_q;
    drain_done_d = 1'b0;
    overrun_d    = overrun_q;
    mem_we       = 1'b0;
    fetch        = 1'b0;
    fc           = rc_q;
    fx           = rx_q;
    fy           = ry_q;
    s_val        = '0;
    m_val        = '0;

    // A drop in the same cycle as a clear leaves the flag set.
    if (i_valid && (state_q != S_CAPTURE)) overrun_d = 1'b1;
    else if (i_clear)                      overrun_d = 1'b0;

    case (state_q)
      S_CAPTURE: begin
        if (i_valid) begin
          mem_we = 1'b1;
          for (int c = 0; c < CO; c++) begin
            s_val = i_fmap[c*O_F_BW +: O_F_BW];
            m_val = max_q[c*O_F_BW +: O_F_BW];
            if (((wx_q == '0) && (wy_q == '0)) || ($signed(s_val) > $signed(m_val)))
              max_d[c*O_F_BW +: O_F_BW] = s_val;
          end
          if (wx_q == X_MAX) begin
            wx_d = '0;
            if (wy_q == Y_MAX) begin
              wy_d         = '0;
              state_d      = S_DONE;
              frame_done_d = 1'b1;
            end else begin
              wy_d = wy_q + YW'(1);
            end
          end else begin
            wx_d = wx_q + XW'(1);
          end
        end
      end
      S_DONE: begin
        argmax_d = best_ch;
        fetch    = 1'b1;
        fc       = '0;
        fx       = '0;
        fy       = '0;
        state_d  = S_DRAIN;
      end
      S_DRAIN: begin
        if (valid_q && i_ready) begin
          if (last_q) begin
            valid_d      = 1'b0;
            last_d       = 1'b0;
            drain_done_d = 1'b1;
            state_d      = S_CAPTURE;
          end else begin
            fetch = 1'b1;
          end
        end
      end
      default: state_d = S_CAPTURE;
    endcase

    // Synchronous read: the registered pointer addresses memory, the sample lands
    // straight in the output register, so a handshake every cycle has no bubbles.
    rd_addr = AW'(32'(fy) * OUT_W + 32'(fx));
    rd_word = mem[rd_addr];
    rd_sel  = rd_word[O_F_BW-1:0];
    for (int c = 1; c < CO; c++) begin
      if (CW'(c) == fc) rd_sel = rd_word[c*O_F_BW +: O_F_BW];
    end

    if (fetch) begin
      valid_d = 1'b1;
      data_d  = rd_sel;
      ch_d    = fc;
      x_d     = fx;
      y_d     = fy;
      last_d  = (fc == C_MAX) && (fx == X_MAX) && (fy == Y_MAX);
      // Advance the pointer past the element just fetched.
      rc_d = fc;
      rx_d = fx;
      ry_d = fy;
      if (ORDER == 0) begin
        if (fx == X_MAX) begin
          rx_d = '0;
          if (fy == Y_MAX) begin
            ry_d = '0;
            rc_d = (fc == C_MAX) ? '0 : fc + CW'(1);
          end else begin
            ry_d = fy + YW'(1);
          end
        end else begin
          rx_d = fx + XW'(1);
        end
      end else begin
        if (fc == C_MAX) begin
          rc_d = '0;
          if (fx == X_MAX) begin
            rx_d = '0;
            ry_d = (fy == Y_MAX) ? '0 : fy + YW'(1);
          end else begin
            rx_d = fx + XW'(1);
          end
        end else begin
          rc_d = fc + CW'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CAPTURE;
      wx_q         <= '0;
      wy_q         <= '0;
      rc_q         <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      max_q        <= '0;
      argmax_q     <= '0;
      frame_done_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      ch_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      last_q       <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      rc_q         <= rc_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      max_q        <= max_d;
      argmax_q     <= argmax_d;
      frame_done_q <= frame_done_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      ch_q         <= ch_d;
      x_q          <= x_d;
      y_q          <= y_d;
      last_q       <= last_d;
      drain_done_q <= drain_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_frame_done = frame_done_q;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_ch         = ch_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_last       = last_q;
  assign o_drain_done = drain_done_q;
  assign o_ch_max     = max_q;
  assign o_argmax     = argmax_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_fmap_frame_buffer.sv
// Testbench for fmap_frame_buffer: two instances (channel-major and pixel-major
// replay) share all inputs; a frame-level reference model supplies every expected
// replay element, maximum and argmax.
module tb_fmap_frame_buffer;

  localparam int CO = 3;
  localparam int BW = 20;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct {
    logic [BW-1:0] d;
    int            c;
    int            x;
    int            y;
  } elem_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_valid;
  logic [CO*BW-1:0] i_fmap;
  logic             i_clear;
  logic             i_ready;

  logic             o_frame_done_0, o_valid_0, o_last_0, o_drain_done_0, o_overrun_0;
  logic [BW-1:0]    o_data_0;
  logic [1:0]       o_ch_0, o_x_0, o_y_0, o_argmax_0;
  logic [CO*BW-1:0] o_ch_max_0;
  logic             o_frame_done_1, o_valid_1, o_last_1, o_drain_done_1, o_overrun_1;
  logic [BW-1:0]    o_data_1;
  logic [1:0]       o_ch_1, o_x_1, o_y_1, o_argmax_1;
  logic [CO*BW-1:0] o_ch_max_1;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [BW-1:0] fr [CO][H][W];

  always #5 clk = ~clk;

  fmap_frame_buffer #(.CO(CO), .O_F_BW(BW), .OUT_W(W), .OUT_H(H), .ORDER(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_fmap(i_fmap), .i_clear(i_clear),
    .o_frame_done(o_frame_done_0), .o_valid(o_valid_0), .i_ready(i_ready),
    .o_data(o_data_0), .o_ch(o_ch_0), .o_x(o_x_0), .o_y(o_y_0), .o_last(o_last_0),
    .o_drain_done(o_drain_done_0), .o_ch_max(o_ch_max_0), .o_argmax(o_argmax_0),
    .o_overrun(o_overrun_0)
  );

  fmap_frame_buffer #(.CO(CO), .O_F_BW(BW), .OUT_W(W), .OUT_H(H), .ORDER(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_fmap(i_fmap), .i_clear(i_clear),
    .o_frame_done(o_frame_done_1), .o_valid(o_valid_1), .i_ready(i_ready),
    .o_data(o_data_1), .o_ch(o_ch_1), .o_x(o_x_1), .o_y(o_y_1), .o_last(o_last_1),
    .o_drain_done(o_drain_done_1), .o_ch_max(o_ch_max_1), .o_argmax(o_argmax_1),
    .o_overrun(o_overrun_1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CO*BW-1:0] pix(input int y, input int x);
    return {fr[2][y][x], fr[1][y][x], fr[0][y][x]};
  endfunction

  function automatic logic [CO*BW-1:0] model_max();
    logic [CO*BW-1:0]     r;
    logic signed [BW-1:0] m;
    r = '0;
    for (int c = 0; c < CO; c++) begin
      m = fr[c][0][0];
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (fr[c][y][x] > m) m = fr[c][y][x];
      r[c*BW +: BW] = m;
    end
    return r;
  endfunction

  function automatic int model_argmax();
    logic [CO*BW-1:0] mx;
    int best;
    mx = model_max();
    best = 0;
    for (int c = 1; c < CO; c++)
      if ($signed(mx[c*BW +: BW]) > $signed(mx[best*BW +: BW])) best = c;
    return best;
  endfunction

  task automatic fill_pattern();
    for (int c = 0; c < CO; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          fr[c][y][x] = BW'((c << 8) | (y << 4) | x);
  endtask

  task automatic fill_random();
    for (int c = 0; c < CO; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          fr[c][y][x] = BW'($urandom);
  endtask

  task automatic fill_negative();
    for (int c = 0; c < CO; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          fr[c][y][x] = BW'(-int'($urandom_range(1, 5000)));
  endtask

  // ch0 all -5 but one -1; ch1 and ch2 both peak at 0x7FFFF (tie, lowest index wins).
  task automatic fill_signed();
    for (int c = 0; c < CO; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          fr[c][y][x] = (c == 0) ? BW'(-5) : BW'(int'($urandom_range(0, 2000)) - 1000);
    fr[0][$urandom_range(0, H-1)][$urandom_range(0, W-1)] = BW'(-1);
    fr[1][$urandom_range(0, H-1)][$urandom_range(0, W-1)] = 20'h7FFFF;
    fr[2][$urandom_range(0, H-1)][$urandom_range(0, W-1)] = 20'h7FFFF;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_frame_done"}, 64'(o_frame_done_0), 64'(0));
    check_val({tag, "_valid"},      64'(o_valid_0),      64'(0));
    check_val({tag, "_data"},       64'(o_data_0),       64'(0));
    check_val({tag, "_tags"},       64'({o_ch_0, o_x_0, o_y_0}), 64'(0));
    check_val({tag, "_last"},       64'(o_last_0),       64'(0));
    check_val({tag, "_drain_done"}, 64'(o_drain_done_0), 64'(0));
    check_val({tag, "_ch_max"},     64'(o_ch_max_0),     64'(0));
    check_val({tag, "_argmax"},     64'(o_argmax_0),     64'(0));
    check_val({tag, "_overrun"},    64'(o_overrun_0),    64'(0));
    check_val({tag, "_all_ord1"}, 64'(|{o_frame_done_1, o_valid_1, o_data_1, o_ch_1, o_x_1,
              o_y_1, o_last_1, o_drain_done_1, o_ch_max_1, o_argmax_1, o_overrun_1}), 64'(0));
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_ready = 1'b0;
    #2;
    check_reset_vals(tag);
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Feeds the 16 beats of fr; returns in the cycle after the last accepted beat.
  task automatic capture(input bit gaps);
    int beats = 0;
    int cyc = 0;
    while (beats < W*H && cyc < 400) begin
      if (!gaps || $urandom_range(0, 2) != 0) begin
        i_valid = 1'b1;
        i_fmap  = pix(beats / W, beats % W);
        beats++;
      end else begin
        i_valid = 1'b0;
        i_fmap  = CO*BW'({$urandom, $urandom});
      end
      step();
      cyc++;
      i_valid = 1'b0;
      if (beats < W*H) check_val("no_early_done", 64'(o_frame_done_0 | o_frame_done_1), 64'(0));
    end
    check_val("frame_done", 64'({o_frame_done_0, o_frame_done_1, o_valid_0, o_valid_1}), 64'(4'b1100));
  endtask

  // DONE cycle -> first replay cycle; checks pulse width, valid rise and maxima.
  task automatic done_phase();
    step();
    check_val("frame_done_pulse", 64'({o_frame_done_0, o_frame_done_1}), 64'(0));
    check_val("valid_rise",       64'({o_valid_0, o_valid_1}), 64'(2'b11));
    check_val("ch_max_ord0",      64'(o_ch_max_0), 64'(model_max()));
    check_val("ch_max_ord1",      64'(o_ch_max_1), 64'(model_max()));
    check_val("argmax_ord0",      64'(o_argmax_0), 64'(model_argmax()));
    check_val("argmax_ord1",      64'(o_argmax_1), 64'(model_argmax()));
  endtask

  // Consumes the replay; stop_after > 0 abandons it after that many handshakes.
  task automatic drain(input bit rand_ready, input bit inject, input int stop_after);
    elem_t q0[$];
    elem_t q1[$];
    elem_t e;
    int cyc = 0;
    int popped = 0;
    for (int c = 0; c < CO; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          e = '{fr[c][y][x], c, x, y};
          q0.push_back(e);
        end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < CO; c++) begin
          e = '{fr[c][y][x], c, x, y};
          q1.push_back(e);
        end
    while (q0.size() > 0 && cyc < 1000 && !(stop_after > 0 && popped == stop_after)) begin
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_valid = inject && (cyc == 3 || cyc == 9 || cyc == 15);
      i_clear = i_valid;
      i_fmap  = CO*BW'({$urandom, $urandom});
      check_val("drain_valid", 64'({o_valid_0, o_valid_1}), 64'(2'b11));
      check_val("data_ord0", 64'(o_data_0), 64'(q0[0].d));
      check_val("tags_ord0", 64'({o_ch_0, o_y_0, o_x_0}), 64'({2'(q0[0].c), 2'(q0[0].y), 2'(q0[0].x)}));
      check_val("last_ord0", 64'(o_last_0), 64'(q0.size() == 1));
      check_val("data_ord1", 64'(o_data_1), 64'(q1[0].d));
      check_val("tags_ord1", 64'({o_ch_1, o_y_1, o_x_1}), 64'({2'(q1[0].c), 2'(q1[0].y), 2'(q1[0].x)}));
      check_val("last_ord1", 64'(o_last_1), 64'(q1.size() == 1));
      if (i_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        popped++;
      end
      step();
      cyc++;
    end
    i_valid = 1'b0;
    i_clear = 1'b0;
    if (stop_after == 0) begin
      check_val("drain_complete", 64'(q0.size()), 64'(0));
      check_val("drain_done", 64'({o_drain_done_0, o_drain_done_1, o_valid_0, o_valid_1}), 64'(4'b1100));
      if (!rand_ready) check_val("drain_cycles", 64'(cyc), 64'(CO*W*H));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_fmap  = '0;
    i_clear = 1'b0;
    i_ready = 1'b0;
    apply_reset("reset");

    // Reference pattern, continuous input, ready held high.
    fill_pattern();
    capture(1'b0);
    done_phase();
    drain(1'b0, 1'b0, 0);

    // Same frame with input gaps and random ready.
    capture(1'b1);
    done_phase();
    drain(1'b1, 1'b0, 0);

    // Signed maxima with a tie between ch1 and ch2.
    fill_signed();
    capture(1'b0);
    done_phase();
    check_val("signed_ch_max", 64'(o_ch_max_0), 64'({20'h7FFFF, 20'h7FFFF, 20'hFFFFF}));
    check_val("signed_argmax", 64'(o_argmax_0), 64'(1));
    drain(1'b1, 1'b0, 0);

    // Beats injected during replay are dropped; clear with a drop keeps the flag set.
    fill_random();
    capture(1'b1);
    done_phase();
    check_val("overrun_before", 64'({o_overrun_0, o_overrun_1}), 64'(0));
    drain(1'b0, 1'b1, 0);
    check_val("overrun_set", 64'({o_overrun_0, o_overrun_1}), 64'(2'b11));
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check_val("overrun_clear", 64'({o_overrun_0, o_overrun_1}), 64'(0));

    fill_pattern();
    capture(1'b0);
    done_phase();
    drain(1'b0, 1'b0, 0);

    // Reset while the beat for pixel (x=2, y=1) is presented.
    fill_random();
    for (int b = 0; b < 6; b++) begin
      i_valid = 1'b1;
      i_fmap  = pix(b / W, b % W);
      step();
    end
    i_valid = 1'b1;
    i_fmap  = pix(1, 2);
    apply_reset("reset_capture");

    // All-negative frame proves the maxima start fresh.
    fill_negative();
    capture(1'b0);
    done_phase();
    drain(1'b1, 1'b0, 0);

    // Reset while replay element 20 is presented.
    capture(1'b0);
    done_phase();
    drain(1'b0, 1'b0, 20);
    apply_reset("reset_drain");

    fill_random();
    capture(1'b1);
    done_phase();
    drain(1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
